reg_xfer_ctrl: RTL
==================

# reg_xfer_ctrl

Sequencer for the general-purpose register file read multiplexer: accepts register-to-register MOV and XCHG commands on a valid/ready handshake and drives the mux selects (`rd_sel`, `rd_size`, `rd_hi`). It captures `rd_data` and issues byte-masked write-backs to the register file. It handles word (16-bit, registers 0-7) and byte (8-bit, high/low halves of registers 0-3) transfers, including cross-half byte moves such as AH→BL. It sits between instruction decode and the register file.

## Interface
- Parameters: none. Data width is fixed at 16 bits and register count at 8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 1: 0 = MOV (dst←src), 1 = XCHG (src↔dst).
- `cmd_size` in 1: 1 = word, 0 = byte.
- `cmd_src` in 3 / `cmd_src_hi` in 1: source register index / byte half (1 = [15:8]).
- `cmd_dst` in 3 / `cmd_dst_hi` in 1: destination register index / byte half.
- `rd_sel` out 3, `rd_size` out 1, `rd_hi` out 1: selects to the read mux.
- `rd_data` in 16: mux output. In byte mode it is zero-padded, with the byte in the half given by `rd_hi`.
- `wr_en` out 1, `wr_sel` out 3, `wr_data` out 16, `wr_mask` out 2: register write port. `wr_mask[1]` enables byte [15:8] and `wr_mask[0]` enables byte [7:0].
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation
- Moore FSM with states IDLE, RD_A, RD_B, WR_A, WR_B, DONE, ERR.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch all `cmd_*` fields.
  - If byte size and (src>3 or dst>3), go to ERR.
  - Otherwise go to RD_A.
- RD_A:
  - Drive `rd_sel`=src, `rd_size`=size, `rd_hi`=src_hi.
  - Register `rd_data` into tmp_a.
  - Go to RD_B if XCHG, else WR_A.
- RD_B:
  - Drive `rd_sel`=dst, `rd_hi`=dst_hi.
  - Register `rd_data` into tmp_b.
  - Go to WR_A.
- WR_A:
  - `wr_en`=1, `wr_sel`=dst, write aligned tmp_a using src_hi extraction and dst_hi mask.
  - Go to WR_B if XCHG, else DONE.
- WR_B:
  - `wr_en`=1, `wr_sel`=src, write aligned tmp_b using dst_hi extraction and src_hi mask.
  - Go to DONE.
- DONE: `done`=1, then IDLE. ERR: `err`=1, then IDLE.
- Alignment, word: `wr_data`=tmp, `wr_mask`=2'b11.
- Alignment, byte:
  - Extract b = hi_from ? tmp[15:8] : tmp[7:0].
  - `wr_data`={b,b}.
  - `wr_mask`= hi_to ? 2'b10 : 2'b01.
- Both operands are read before any write, so XCHG is correct even when src==dst or both halves belong to the same register (e.g. AH↔AL).
- Outputs not driven by the current state are 0.

## Timing
- Reset values:
  - state=IDLE, tmp_a=tmp_b=0.
  - `wr_en`, `wr_sel`, `wr_data`, `wr_mask`, `done`, `err`, `rd_sel`, `rd_size`, `rd_hi` all 0.
  - `cmd_ready`=0 while `rst` is high and 1 after release.
- Latency from the accept edge to the `done` cycle:
  - MOV: RD_A, WR_A, DONE, so `done` is high in the 3rd cycle after accept.
  - XCHG: `done` is high in the 5th cycle after accept.
  - ERR: `err` is high in the 1st cycle after accept.
- The register file updates on the edge ending a WR state; a following command sees the new value.
- `cmd_ready` is low from the accept edge until the controller returns to IDLE. Back-to-back throughput: one MOV per 4 cycles.
- `cmd_*` inputs are ignored outside IDLE, and `cmd_valid` may drop after the accept edge.
- Reset mid-operation: the FSM returns to IDLE asynchronously and `wr_en` deasserts immediately. The pending write is dropped and neither `done` nor `err` is produced.

## Structure
- Package `reg_xfer_pkg`:
  - State enum.
  - Op codes OP_MOV/OP_XCHG.
  - Mask constants MASK_WORD/MASK_HI/MASK_LO.
  - Register index constants REG_AX..REG_DI (0-7).
- Sub-module `reg_byte_align` (combinational): inputs tmp, size, hi_from, hi_to; outputs `wr_data` and `wr_mask`. It is instantiated once and muxed between WR_A and WR_B operands.

## Test plan
- Word MOV, reg0=16'h1234, src=0 dst=5 → WR_A: `wr_sel`=5, `wr_data`=16'h1234, `wr_mask`=2'b11; `done` 3 cycles after accept; reg5=16'h1234.
- Byte MOV AH→BL, reg0=16'hAB12, reg3=16'h7788, src=0 hi=1, dst=3 hi=0 → `wr_data`=16'hABAB, `wr_mask`=2'b01; reg3=16'h77AB.
- Word XCHG reg1=16'h1111, reg2=16'h2222 → writes reg2←1111 then reg1←2222; `done` 5 cycles after accept.
- Byte XCHG AH↔AL, reg0=16'h12AB → reg0=16'hAB12 after `done`.
- Byte op with dst=5 → `err` pulses 1 cycle after accept, no `wr_en`, `cmd_ready` returns next cycle.
- `rst` asserted during WR_A → `wr_en`=0 immediately, target register unchanged, no `done`, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/reg_xfer_pkg.sv
// Shared types and constants for the register-to-register transfer sequencer.
package reg_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WR_A,
    ST_WR_B,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic OP_MOV  = 1'b0;
  localparam logic OP_XCHG = 1'b1;

  localparam logic [1:0] MASK_WORD = 2'b11;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_LO   = 2'b01;

  localparam logic [2:0] REG_AX = 3'd0;
  localparam logic [2:0] REG_CX = 3'd1;
  localparam logic [2:0] REG_DX = 3'd2;
  localparam logic [2:0] REG_BX = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;
  localparam logic [2:0] REG_SI = 3'd6;
  localparam logic [2:0] REG_DI = 3'd7;

  typedef struct packed {
    logic       op;
    logic       size;
    logic [2:0] src;
    logic       src_hi;
    logic [2:0] dst;
    logic       dst_hi;
  } cmd_t;

  // Only AX..BX have addressable byte halves.
  function automatic logic byte_reg_ok(input logic [2:0] idx);
    return (idx <= REG_BX);
  endfunction

endpackage

// File: rtl/reg_byte_align.sv
// Aligns a captured operand for write-back: word pass-through or byte
// extraction replicated into both halves with a single-half write mask.
module reg_byte_align
  import reg_xfer_pkg::*;
(
  input  logic [15:0] tmp,
  input  logic        size,
  input  logic        hi_from,
  input  logic        hi_to,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_mask
);

  logic [7:0] b;

  always_comb begin
    b       = hi_from ? tmp[15:8] : tmp[7:0];
    wr_data = '0;
    wr_mask = '0;
    if (size) begin
      wr_data = tmp;
      wr_mask = MASK_WORD;
    end else begin
      wr_data = {b, b};
      wr_mask = hi_to ? MASK_HI : MASK_LO;
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// MOV/XCHG sequencer between decode and the register file: reads both
// operands through the read mux before issuing byte-masked write-backs.
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic        cmd_size,
  input  logic [2:0]  cmd_src,
  input  logic        cmd_src_hi,
  input  logic [2:0]  cmd_dst,
  input  logic        cmd_dst_hi,
  output logic [2:0]  rd_sel,
  output logic        rd_size,
  output logic        rd_hi,
  input  logic [15:0] rd_data,
  output logic        wr_en,
  output logic [2:0]  wr_sel,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_mask,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [15:0] tmp_a_q, tmp_a_d;
  logic [15:0] tmp_b_q, tmp_b_d;

  logic [15:0] al_tmp;
  logic        al_hi_from;
  logic        al_hi_to;
  logic [15:0] al_data;
  logic [1:0]  al_mask;
  logic        accept;

  // Ready is gated by rst so it reads low for the whole reset window.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tmp_a_d = tmp_a_q;
    tmp_b_d = tmp_b_q;
    rd_sel  = '0;
    rd_size = 1'b0;
    rd_hi   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = '0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d.op     = cmd_op;
          cmd_d.size   = cmd_size;
          cmd_d.src    = cmd_src;
          cmd_d.src_hi = cmd_src_hi;
          cmd_d.dst    = cmd_dst;
          cmd_d.dst_hi = cmd_dst_hi;
          if (!cmd_size && !(byte_reg_ok(cmd_src) && byte_reg_ok(cmd_dst)))
            state_d = ST_ERR;
          else
            state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        rd_sel  = cmd_q.src;
        rd_size = cmd_q.size;
        rd_hi   = cmd_q.src_hi;
        tmp_a_d = rd_data;
        state_d = (cmd_q.op == OP_XCHG) ? ST_RD_B : ST_WR_A;
      end
      ST_RD_B: begin
        rd_sel  = cmd_q.dst;
        rd_size = cmd_q.size;
        rd_hi   = cmd_q.dst_hi;
        tmp_b_d = rd_data;
        state_d = ST_WR_A;
      end
      ST_WR_A: begin
        wr_en   = 1'b1;
        wr_sel  = cmd_q.dst;
        state_d = (cmd_q.op == OP_XCHG) ? ST_WR_B : ST_DONE;
      end
      ST_WR_B: begin
        wr_en   = 1'b1;
        wr_sel  = cmd_q.src;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One aligner shared by both write states; WR_B swaps operand roles.
  always_comb begin
    if (state_q == ST_WR_B) begin
      al_tmp     = tmp_b_q;
      al_hi_from = cmd_q.dst_hi;
      al_hi_to   = cmd_q.src_hi;
    end else begin
      al_tmp     = tmp_a_q;
      al_hi_from = cmd_q.src_hi;
      al_hi_to   = cmd_q.dst_hi;
    end
  end

  reg_byte_align u_align (
    .tmp     (al_tmp),
    .size    (cmd_q.size),
    .hi_from (al_hi_from),
    .hi_to   (al_hi_to),
    .wr_data (al_data),
    .wr_mask (al_mask)
  );

  assign wr_data = wr_en ? al_data : '0;
  assign wr_mask = wr_en ? al_mask : '0;

endmodule
